// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: valid/ready byte in, 8-data-bit LSB-first UART frame out on TX.
// Frame: start, 8 data bits, optional parity, STOP_BITS stop bits.
// Each bit is held for DIVISOR enabled clock cycles.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, a parity bit
// follows the data bits: even for PARITY_ODD=0, odd for PARITY_ODD=1.
module uart_tx_serializer #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX,
    output logic       BUSY
);

    localparam int unsigned DIVISOR = (CLK_HZ + (BAUD / 2)) / BAUD;
    localparam int unsigned CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DIVISOR - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    // PARITY is reachable only when the parity feature is compiled in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             par_c;

    // Parity over the latched byte; odd parity inverts the XOR reduction
    assign par_c = (^shift_q) ^ 1'(PARITY_ODD);

    // Next-state: accept in IDLE, otherwise count down the bit and advance on zero
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        if (ENABLE) begin
            if (state_q == IDLE) begin
                if (TX_VALID && ready_q) begin
                    shift_d   = TX_DATA;
                    state_d   = START;
                    cnt_d     = CNT_LOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                cnt_d = CNT_LOAD;
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                        tx_d      = shift_q[0];
                    end
                    DATA: begin
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                            state_d   = PARITY;
                            tx_d      = par_c;
`else
                            state_d   = STOP;
                            tx_d      = 1'b1;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            tx_d      = shift_q[bit_idx_q + 3'd1];
                        end
                    end
                    PARITY: begin
                        state_d   = STOP;
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b1;
                    end
                    STOP: begin
                        if (bit_idx_q == LAST_STOP) begin
                            state_d   = IDLE;
                            bit_idx_d = 3'd0;
                            cnt_d     = '0;
                            tx_d      = 1'b1;
                            ready_d   = 1'b1;
                            busy_d    = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        bit_idx_d = 3'd0;
                        cnt_d     = '0;
                        tx_d      = 1'b1;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset aborts any frame and idles the line high
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign TX       = tx_q;
    assign TX_READY = ready_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: expected line waveform built as a list of
// frame bits, each expected to last DIVISOR cycles (plus any disabled cycles).
module tb_uart_tx_serializer;

    localparam int unsigned CLK_HZ     = 1_000_000;
    localparam int unsigned BAUD       = 100_000;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned PARITY_ODD = 0;
    localparam int          D          = 10;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ENABLE;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic       TX;
    logic       BUSY;

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    uart_tx_serializer #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ENABLE  (ENABLE),
        .TX_DATA (TX_DATA),
        .TX_VALID(TX_VALID),
        .TX_READY(TX_READY),
        .TX      (TX),
        .BUSY    (BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // n cycles of idle line: TX high, ready, not busy
    task automatic idle_check(input string tag, input int n);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if ({TX, TX_READY, BUSY} !== 3'b110) ok = 1'b0;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // Wait for a start bit, then check every cycle of the expected frame.
    // exp_gap: extra idle cycles expected before the start bit (-1 = unchecked).
    // dis_*: drop ENABLE for dis_len cycles at offset dis_off of frame bit dis_bit.
    // abort_*: pull RESET low at that point and check the line idles at once.
    task automatic run_frame(input string tag, input logic [7:0] d, input int exp_gap,
                             input logic keep_valid, input logic [7:0] next_data,
                             input int dis_bit, input int dis_off, input int dis_len,
                             input int abort_bit, input int abort_off);
        logic       bits[$];
        int         idle;
        int         dur;
        logic [7:0] dec;
        bit         ok;
        bit         first;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back((PARITY_ODD != 0) ? ~^d : ^d);
`endif
        for (int i = 0; i < int'(STOP_BITS); i++) bits.push_back(1'b1);

        idle = 0;
        @(negedge CLK);
        while (TX !== 1'b0 && idle < 200) begin
            idle++;
            @(negedge CLK);
        end
        chk({tag, "_start"}, 32'(TX), 32'd0);
        if (TX !== 1'b0) return;
        if (exp_gap >= 0) chk({tag, "_gap"}, 32'(idle), 32'(exp_gap));
        TX_VALID = keep_valid;
        TX_DATA  = next_data;

        dec   = 8'd0;
        first = 1'b1;
        for (int k = 0; k < bits.size(); k++) begin
            dur = D + ((k == dis_bit) ? dis_len : 0);
            ok  = 1'b1;
            for (int j = 0; j < dur; j++) begin
                if (!first) @(negedge CLK);
                first = 1'b0;
                if (TX !== bits[k] || TX_READY !== 1'b0 || BUSY !== 1'b1) ok = 1'b0;
                if (k >= 1 && k <= 8 && j == D / 2) dec[k-1] = TX;
                if (dis_len > 0 && k == dis_bit && j == dis_off) ENABLE = 1'b0;
                if (dis_len > 0 && k == dis_bit && j == dis_off + dis_len) ENABLE = 1'b1;
                if (k == abort_bit && j == abort_off) begin
                    chk($sformatf("%s_bit%0d", tag, k), 32'(ok), 32'd1);
                    RESET = 1'b0;
                    #1;
                    chk({tag, "_abort"}, 32'({TX, TX_READY, BUSY}), 32'(3'b110));
                    return;
                end
            end
            chk($sformatf("%s_bit%0d", tag, k), 32'(ok), 32'd1);
        end
        @(negedge CLK);
        chk({tag, "_ready"}, 32'({TX, TX_READY, BUSY}), 32'(3'b110));
        chk({tag, "_decode"}, 32'(dec), 32'(d));
    endtask

    logic [7:0] rb [8];
    bit         b2b [9];

    initial begin
        RESET    = 1'b0;
        ENABLE   = 1'b1;
        TX_VALID = 1'b0;
        TX_DATA  = 8'h00;

        // Reset held, then released: line idle throughout
        idle_check("reset_hold", 5);
        RESET = 1'b1;
        idle_check("reset_release", 5);

        // No accept while disabled; dropping VALID before accept does nothing
        ENABLE   = 1'b0;
        TX_DATA  = 8'h99;
        TX_VALID = 1'b1;
        idle_check("en_off_no_accept", 4);
        TX_VALID = 1'b0;
        ENABLE   = 1'b1;
        idle_check("valid_dropped", 6);

        // Single frame 0x55 offered for one cycle; data changes while busy ignored
        TX_DATA  = 8'h55;
        TX_VALID = 1'b1;
        run_frame("f55", 8'h55, 0, 1'b0, 8'hFF, -1, 0, 0, -1, 0);
        idle_check("after_f55", 3);

        // Back-to-back 0xA5 then 0x3C with VALID held
        TX_DATA  = 8'hA5;
        TX_VALID = 1'b1;
        run_frame("fA5", 8'hA5, -1, 1'b1, 8'h3C, -1, 0, 0, -1, 0);
        run_frame("f3C", 8'h3C, 0, 1'b0, 8'h00, -1, 0, 0, -1, 0);
        idle_check("after_f3C", 3);

        // 0xF0 with ENABLE low for 7 cycles inside data bit 3
        TX_DATA  = 8'hF0;
        TX_VALID = 1'b1;
        run_frame("fF0", 8'hF0, -1, 1'b0, 8'h12, 4, 2, 7, -1, 0);
        idle_check("after_fF0", 3);

        // Reset during data bit 4 aborts; next 0x00 frame is clean
        TX_DATA  = 8'hC3;
        TX_VALID = 1'b1;
        run_frame("fC3", 8'hC3, -1, 1'b0, 8'h00, -1, 0, 0, 5, 4);
        idle_check("abort_hold", 2);
        RESET = 1'b1;
        idle_check("abort_release", 4);
        TX_DATA  = 8'h00;
        TX_VALID = 1'b1;
        run_frame("f00", 8'h00, 0, 1'b0, 8'hAA, -1, 0, 0, -1, 0);

        // 0x07: parity bit (when compiled in) and overall frame length
        TX_DATA  = 8'h07;
        TX_VALID = 1'b1;
        run_frame("f07", 8'h07, 0, 1'b0, 8'h00, -1, 0, 0, -1, 0);

        // Random bytes, random gaps / back-to-back, random enable stretches
        for (int i = 0; i < 8; i++) begin
            rb[i]  = 8'($urandom);
            b2b[i] = (i > 0) && ($urandom_range(0, 1) == 1);
        end
        b2b[8] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int dbit;
            int doff;
            int dlen;
            if (!b2b[i]) begin
                idle_check($sformatf("rnd%0d_idle", i), $urandom_range(1, 4));
                TX_DATA  = rb[i];
                TX_VALID = 1'b1;
            end
            dbit = $urandom_range(0, 9);
            doff = $urandom_range(0, D - 1);
            dlen = $urandom_range(0, 6);
            run_frame($sformatf("rnd%0d", i), rb[i], b2b[i] ? 0 : -1, b2b[i+1],
                      b2b[i+1] ? rb[(i < 7) ? i + 1 : 7] : 8'($urandom),
                      dbit, doff, dlen, -1, 0);
        end
        idle_check("final_idle", 5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
